// File: rtl/ada_pc_sequencer.sv
// ada_pc_sequencer: next-PC selection for the IA/IF pipeline register.
// Latency: combinational; redirects appear on pc_next in the request cycle.
// Backpressure: while if_stall is high a redirect is buffered (PEND) and
//   flushed on release; a buffered redirect can only be replaced by an equal
//   or higher ranked one.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pc_current                 PC held in the IA/IF register
//   if_stall                   IF stalled, IA/IF register holds
//   exc_*/eret_*/br_*          redirect requests and targets (exc > eret > br)
//   pc_next                    next PC to the IA/IF register
//   if_flush                   kill the IF instruction (combinational)
//   redirect_pending           registered, high while a redirect is buffered

`ifndef ADA_RESET_DEFAULT
`define ADA_RESET_DEFAULT 32'hBFC0_0000
`endif

module ada_pc_sequencer #(
  parameter logic [31:0] RESET_PC = `ADA_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_current,
  input  logic        if_stall,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  input  logic        eret_req,
  input  logic [31:0] eret_target,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic [31:0] pc_next,
  output logic        if_flush,
  output logic        redirect_pending
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_tgt;
  logic [1:0]  r_rank;
  logic        r_pending;

  logic [1:0]  w_sel_rank;
  logic [31:0] w_sel_tgt;
  logic        w_take;
  logic [31:0] w_win_tgt;

  // Priority select; rank 3/2/1 for exc/eret/br, 0 when idle.
  // Targets are word aligned before they are used or stored.
  always_comb begin
    w_sel_rank = 2'd0;
    w_sel_tgt  = 32'h0;
    if (exc_req) begin
      w_sel_rank = 2'd3;
      w_sel_tgt  = {exc_target[31:2], 2'b00};
    end else if (eret_req) begin
      w_sel_rank = 2'd2;
      w_sel_tgt  = {eret_target[31:2], 2'b00};
    end else if (br_req) begin
      w_sel_rank = 2'd1;
      w_sel_tgt  = {br_target[31:2], 2'b00};
    end
  end

  // r_rank is 0 outside PEND, so in RUN this reduces to "any request".
  // In PEND an equal rank wins so the youngest same-class redirect is kept.
  assign w_take    = (w_sel_rank != 2'd0) && (w_sel_rank >= r_rank);
  assign w_win_tgt = w_take ? w_sel_tgt : r_tgt;

  always_comb begin
    pc_next  = pc_current + 32'd4;
    if_flush = 1'b0;
    if (rst) begin
      pc_next  = RESET_PC;
      if_flush = 1'b0;
    end else if (r_state == RUN) begin
      if (w_take) begin
        pc_next  = w_sel_tgt;
        // Under stall the IF instruction is killed later, on release.
        if_flush = ~if_stall;
      end
    end else begin
      pc_next  = w_win_tgt;
      if_flush = ~if_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pending <= 1'b0;
      r_tgt     <= RESET_PC;
      r_rank    <= 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_take && if_stall) begin
            r_tgt     <= w_sel_tgt;
            r_rank    <= w_sel_rank;
            r_state   <= PEND;
            r_pending <= 1'b1;
          end
        end
        PEND: begin
          if (if_stall) begin
            if (w_take) begin
              r_tgt  <= w_sel_tgt;
              r_rank <= w_sel_rank;
            end
          end else begin
            r_tgt     <= w_win_tgt;
            r_rank    <= 2'd0;
            r_state   <= RUN;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= RUN;
          r_pending <= 1'b0;
          r_rank    <= 2'd0;
        end
      endcase
    end
  end

  assign redirect_pending = r_pending;

endmodule

// File: tb/tb_ada_pc_sequencer.sv
module tb_ada_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_current;
  logic        if_stall;
  logic        exc_req;
  logic [31:0] exc_target;
  logic        eret_req;
  logic [31:0] eret_target;
  logic        br_req;
  logic [31:0] br_target;
  logic [31:0] pc_next;
  logic        if_flush;
  logic        redirect_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ada_pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_current       (pc_current),
    .if_stall         (if_stall),
    .exc_req          (exc_req),
    .exc_target       (exc_target),
    .eret_req         (eret_req),
    .eret_target      (eret_target),
    .br_req           (br_req),
    .br_target        (br_target),
    .pc_next          (pc_next),
    .if_flush         (if_flush),
    .redirect_pending (redirect_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic no_req();
    exc_req  = 1'b0;
    eret_req = 1'b0;
    br_req   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    pc_current  = 32'h0;
    if_stall    = 1'b1;
    exc_req     = 1'b1;
    exc_target  = 32'h8000_0180;
    eret_req    = 1'b0;
    eret_target = 32'h0;
    br_req      = 1'b0;
    br_target   = 32'h0;

    // Reset, with a request and stall present that must be ignored
    tick(); tick(); settle();
    check("rst_pc_next", pc_next, RST_PC);
    check("rst_flush", {31'b0, if_flush}, 32'd0);
    check("rst_pending", {31'b0, redirect_pending}, 32'd0);

    // First cycle after reset: sequential from RESET_PC
    tick();
    rst = 1'b0; no_req(); if_stall = 1'b0; pc_current = RST_PC;
    settle();
    check("post_rst_seq", pc_next, 32'h0000_1004);
    check("post_rst_flush", {31'b0, if_flush}, 32'd0);

    // Sequential fetch and wrap
    tick(); pc_current = 32'h0000_0100; settle();
    check("seq_100", pc_next, 32'h0000_0104);
    check("seq_flush", {31'b0, if_flush}, 32'd0);
    tick(); pc_current = 32'hFFFF_FFFC; settle();
    check("seq_wrap", pc_next, 32'h0000_0000);

    // Simultaneous exc + br, unstalled: exc wins, flush now
    tick();
    exc_req = 1'b1; exc_target = 32'h8000_0180;
    br_req = 1'b1; br_target = 32'h0000_2000;
    settle();
    check("simul_pc", pc_next, 32'h8000_0180);
    check("simul_flush", {31'b0, if_flush}, 32'd1);

    // eret beats br; low bits of target forced to 0
    tick();
    exc_req = 1'b0; eret_req = 1'b1; eret_target = 32'h0000_3007;
    settle();
    check("eret_pc", pc_next, 32'h0000_3004);
    check("run_no_pend", {31'b0, redirect_pending}, 32'd0);

    // Buffered branch: three stalled cycles, then release
    tick();
    no_req(); br_req = 1'b1; br_target = 32'h0000_4003; if_stall = 1'b1;
    pc_current = 32'h0000_0200;
    settle();
    check("buf_pc_c0", pc_next, 32'h0000_4000);
    check("buf_flush_c0", {31'b0, if_flush}, 32'd0);
    tick(); br_req = 1'b0; settle();
    check("buf_pc_c1", pc_next, 32'h0000_4000);
    check("buf_pend_c1", {31'b0, redirect_pending}, 32'd1);
    check("buf_flush_c1", {31'b0, if_flush}, 32'd0);
    tick(); settle();
    check("buf_pc_c2", pc_next, 32'h0000_4000);
    check("buf_pend_c2", {31'b0, redirect_pending}, 32'd1);
    tick(); if_stall = 1'b0; settle();
    check("buf_rel_pc", pc_next, 32'h0000_4000);
    check("buf_rel_flush", {31'b0, if_flush}, 32'd1);
    tick(); pc_current = 32'h0000_4000; settle();
    check("buf_after_pc", pc_next, 32'h0000_4004);
    check("buf_after_flush", {31'b0, if_flush}, 32'd0);
    check("buf_after_pend", {31'b0, redirect_pending}, 32'd0);

    // Override: exc replaces buffered br, later br dropped
    tick(); br_req = 1'b1; br_target = 32'h0000_4000; if_stall = 1'b1; settle();
    tick();
    br_req = 1'b0; exc_req = 1'b1; exc_target = 32'h8000_0180;
    settle();
    check("ovr_exc_pc", pc_next, 32'h8000_0180);
    check("ovr_exc_flush", {31'b0, if_flush}, 32'd0);
    tick(); no_req(); settle();
    check("ovr_hold_pc", pc_next, 32'h8000_0180);
    tick(); br_req = 1'b1; br_target = 32'h0000_5000; settle();
    check("ovr_lowrank_pc", pc_next, 32'h8000_0180);
    tick(); no_req(); if_stall = 1'b0; settle();
    check("ovr_rel_pc", pc_next, 32'h8000_0180);
    check("ovr_rel_flush", {31'b0, if_flush}, 32'd1);
    tick(); pc_current = 32'h8000_0180; settle();
    check("ovr_after_pc", pc_next, 32'h8000_0184);
    check("ovr_after_pend", {31'b0, redirect_pending}, 32'd0);

    // Equal rank replaces the buffered target
    tick(); br_req = 1'b1; br_target = 32'h0000_4000; if_stall = 1'b1; settle();
    tick(); br_target = 32'h0000_6002; settle();
    check("eq_rank_pc", pc_next, 32'h0000_6000);
    tick(); no_req(); if_stall = 1'b0; settle();
    check("eq_rank_rel_pc", pc_next, 32'h0000_6000);
    check("eq_rank_rel_flush", {31'b0, if_flush}, 32'd1);

    // Reset while pending discards the buffered redirect
    tick(); br_req = 1'b1; br_target = 32'h0000_7000; if_stall = 1'b1; settle();
    tick(); no_req(); settle();
    check("mid_pend", {31'b0, redirect_pending}, 32'd1);
    rst = 1'b1; settle();
    check("mid_rst_pc", pc_next, RST_PC);
    check("mid_rst_flush", {31'b0, if_flush}, 32'd0);
    tick(); settle();
    check("mid_rst_pend", {31'b0, redirect_pending}, 32'd0);
    tick(); rst = 1'b0; pc_current = RST_PC; if_stall = 1'b0; settle();
    check("mid_after_pc", pc_next, 32'h0000_1004);
    check("mid_after_flush", {31'b0, if_flush}, 32'd0);
    tick(); if_stall = 1'b1; pc_current = 32'h0000_1004; settle();
    check("mid_stale_pc", pc_next, 32'h0000_1008);
    check("mid_stale_pend", {31'b0, redirect_pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ada_pc_sequencer.md
ADA_PC_SEQUENCER -- requirements
Module: ada_pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default `ADA_RESET_DEFAULT, PC driven during and after reset.
REQ-002 clk  in  1  main clock; single clock domain.
REQ-003 rst  in  1  main reset; synchronous, active-high.
REQ-004 pc_current  in  32  PC currently held by the IA/IF pipeline register.
REQ-005 if_stall  in  1  IF stage stalled; the IA/IF register holds its value.
REQ-006 exc_req, exc_target  in  1, 32  exception redirect request and vector.
REQ-007 eret_req, eret_target  in  1, 32  exception-return request and EPC.
REQ-008 br_req, br_target  in  1, 32  taken branch/jump request and target.
REQ-009 pc_next  out  32  next PC, driven to the IA/IF register PC input.
REQ-010 if_flush  out  1  kill the instruction in IF; combinational.
REQ-011 redirect_pending  out  1  a redirect is buffered awaiting stall release; registered.

Function
REQ-012 The block SHALL have two states: RUN and PEND.
REQ-013 Redirect priority SHALL be exc > eret > br; class rank is exc=3, eret=2, br=1, none=0.
REQ-014 Every selected target SHALL have bits [1:0] forced to 0 before use or storage.
REQ-015 RUN, no request: pc_next = pc_current + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); if_flush = 0.
REQ-016 RUN, request, if_stall=0: pc_next = selected target; if_flush = 1; remain in RUN.
REQ-017 RUN, request, if_stall=1: pc_next = selected target; if_flush = 0; latch target and rank; next state PEND.
REQ-018 In PEND, pc_next SHALL equal the stored target, unless REQ-019 applies.
REQ-019 PEND, incoming request with rank >= stored rank: it replaces the stored target and rank, and pc_next = new target that same cycle.
REQ-020 PEND, incoming request with lower rank: it SHALL be ignored and dropped.
REQ-021 PEND, if_stall=1: stay in PEND; if_flush = 0.
REQ-022 PEND, if_stall=0: if_flush = 1; pc_next = winning target per REQ-019/020; next state RUN; stored rank cleared.
REQ-023 redirect_pending SHALL be 1 exactly when the state is PEND.
REQ-024 Latency: a redirect SHALL be visible on pc_next in the same cycle as its request or buffering; there is no added cycle.
REQ-025 No redirect SHALL be lost while stalled, except a lower-rank request per REQ-020.

Reset
REQ-026 While rst=1: pc_next = RESET_PC, if_flush = 0, state = RUN, redirect_pending = 0 on the next edge, stored target = RESET_PC, stored rank = 0.
REQ-027 rst asserted in PEND SHALL discard the buffered redirect; requests during rst SHALL be ignored.
REQ-028 In the first cycle after rst falls, the block SHALL operate per REQ-015..017 with pc_current = RESET_PC.

Verification
REQ-029 Sequential: pc_current=0x0000_0100, no requests, if_stall=0 -> pc_next=0x0000_0104, if_flush=0; pc_current=0xFFFF_FFFC -> pc_next=0x0000_0000.
REQ-030 Simultaneous: exc_req=1 with exc_target=0x8000_0180, br_req=1 with br_target=0x0000_2000, if_stall=0 -> pc_next=0x8000_0180, if_flush=1.
REQ-031 Buffered branch: br_target=0x0000_4003 with if_stall=1 for 3 cycles -> pc_next=0x0000_4000 and redirect_pending=1 throughout; on stall release, if_flush=1 for one cycle, then RUN.
REQ-032 Override: PEND holding br 0x0000_4000, then exc 0x8000_0180 while stalled -> stored target becomes 0x8000_0180; a later br 0x0000_5000 is ignored; release -> pc_next=0x8000_0180, if_flush=1.
REQ-033 Reset mid-PEND: rst=1 -> pc_next=RESET_PC, redirect_pending=0 after the edge; after release, no flush occurs and the stale target never appears on pc_next.
